// File: rtl/beep_pkg.sv
// beep_pkg: shared widths and meter state encoding for the beep generator and meter
package beep_pkg;
  localparam int FREQ_W = 11;
  localparam int FREQ_MAX = 2047;
  typedef enum logic [1:0] {IDLE, COUNT, REPORT} meter_state_t;
endpackage

// File: rtl/beep_edge_sync.sv
// beep_edge_sync: two-flop synchroniser followed by a rising-edge pulse
module beep_edge_sync (
  input  logic clk,
  input  logic rst,
  input  logic din,
  output logic rise
);
  logic s1, s2, sd;
  always_ff @(posedge clk) begin
    if (rst) {s1, s2, sd} <= '0;
    else {s1, s2, sd} <= {din, s1, s2};
  end
  assign rise = s2 & ~sd;
endmodule

// File: rtl/beep_freq_meter.sv
// beep_freq_meter: counts melody rising edges over a gate window and reports the tone code
module beep_freq_meter
  import beep_pkg::*;
#(
  parameter int GATE_CYCLES = 100_000_000,
  parameter int TOL = 2,
  parameter int CNT_W = 27
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              enable,
  input  logic              start,
  input  logic              cont,
  input  logic              melody,
  output logic [FREQ_W-1:0] freq_out,
  output logic              valid,
  output logic              busy,
  output logic              silent,
  output logic              stable
);
  meter_state_t state, state_nx;
  logic [CNT_W-1:0] gate_cnt;
  logic [FREQ_W:0] edge_cnt, prev, diff;
  logic rise, gate_end;
  beep_edge_sync u_sync (.clk(clk), .rst(rst), .din(melody), .rise(rise));
  assign gate_end = gate_cnt == CNT_W'(GATE_CYCLES - 1);
  assign diff = edge_cnt > prev ? edge_cnt - prev : prev - edge_cnt;
  assign valid = state == REPORT;
  assign busy = state == COUNT;
  always_comb begin
    state_nx = state;
    state_nx = state == IDLE  ? (enable && (start || cont) ? COUNT : IDLE) :
               state == COUNT ? (!enable ? IDLE : gate_end ? REPORT : COUNT) :
                                (enable && cont ? COUNT : IDLE);
  end
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else state <= state_nx;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      gate_cnt <= '0;
      edge_cnt <= '0;
      prev     <= '0;
      freq_out <= '0;
      silent   <= 1'b0;
      stable   <= 1'b0;
    end else begin
      if (state != COUNT && state_nx == COUNT) begin
        gate_cnt <= '0;
        edge_cnt <= '0;
      end else if (state == COUNT) begin
        gate_cnt <= gate_cnt + 1'b1;
        if (rise && edge_cnt != (FREQ_W + 1)'(FREQ_MAX)) edge_cnt <= edge_cnt + 1'b1;
      end
      // an aborted window must not let an old result vouch for stability
      if (state == COUNT && !enable) prev <= '0;
      if (state == REPORT) begin
        freq_out <= edge_cnt[FREQ_W-1:0];
        silent   <= edge_cnt == '0;
        stable   <= edge_cnt != '0 && prev != '0 && diff <= (FREQ_W + 1)'(TOL);
        prev     <= edge_cnt;
      end
    end
  end
endmodule
